// File: rtl/bsg_mul_cs_resolve.sv
// bsg_mul_cs_resolve
// Multi-cycle carry-propagate adder that resolves one carry-save pair (s_i, c_i, cin_i)
// into sum_o/cout_o, chunk_p bits per cycle. It processes one operation at a time.
//
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   v_i / ready_o         input handshake; s_i, c_i, cin_i are captured on v_i & ready_o
//   v_o / yumi_i          output handshake; sum_o, cout_o are held stable while v_o=1
//   sum_o                 (s_i + c_i + cin_i) mod 2^width_p
//   cout_o                carry out of bit width_p-1
module bsg_mul_cs_resolve #(
  parameter int unsigned width_p = 32,
  parameter int unsigned chunk_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] s_i,
  input  logic [width_p-1:0] c_i,
  input  logic               cin_i,
  output logic               v_o,
  output logic [width_p-1:0] sum_o,
  output logic               cout_o,
  input  logic               yumi_i
);

  localparam int unsigned chunks_lp = width_p / chunk_p;
  localparam int unsigned cnt_w_lp  = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(chunks_lp - 1);

  if (width_p % chunk_p != 0) begin : g_bad_param
    $error("bsg_mul_cs_resolve: width_p must be a multiple of chunk_p");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [width_p-1:0]    s_q, s_d;
  logic [width_p-1:0]    c_q, c_d;
  logic [width_p-1:0]    sum_q, sum_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;

  logic                  accept;
  logic [chunk_p:0]      chunk_res;
  logic [width_p-1:0]    chunk_ext;

  always_comb begin
    ready_o = (state_q == StIdle) || ((state_q == StDone) && yumi_i);
    accept  = v_i && ready_o;

    // Operands shift right each cycle so the active chunk is always the low slice.
    chunk_res = {1'b0, s_q[chunk_p-1:0]} + {1'b0, c_q[chunk_p-1:0]}
              + (chunk_p + 1)'(carry_q);
    chunk_ext = '0;
    chunk_ext[chunk_p-1:0] = chunk_res[chunk_p-1:0];

    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StBusy;
      end
      StBusy: begin
        s_d     = s_q >> chunk_p;
        c_d     = c_q >> chunk_p;
        carry_d = chunk_res[chunk_p];
        // Result chunks enter at the top; after chunks_lp shifts chunk 0 sits at bit 0.
        sum_d   = (sum_q >> chunk_p) | (chunk_ext << (width_p - chunk_p));
        cnt_d   = cnt_q + cnt_w_lp'(1);
        if (cnt_q == last_cnt_lp) begin
          cout_d  = chunk_res[chunk_p];
          state_d = StDone;
        end
      end
      StDone: begin
        if (yumi_i) state_d = accept ? StBusy : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      s_d     = s_i;
      c_d     = c_i;
      carry_d = cin_i;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign v_o    = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

  // Consumer protocol: yumi_i is only meaningful while a result is presented.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_mul_cs_resolve: yumi_i asserted while v_o=0");
    end
  end

endmodule

// File: tb/tb_bsg_mul_cs_resolve.sv
module tb_bsg_mul_cs_resolve;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v = 1'b0, yumi = 1'b0, cin = 1'b0;
  logic        v1 = 1'b0, yumi1 = 1'b0;
  logic [15:0] s = '0, c = '0;
  logic        ready, v_o, cout;
  logic        ready1, v_o1, cout1;
  logic [15:0] sum, sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_mul_cs_resolve #(.width_p(16), .chunk_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready), .s_i(s), .c_i(c),
    .cin_i(cin), .v_o(v_o), .sum_o(sum), .cout_o(cout), .yumi_i(yumi)
  );

  bsg_mul_cs_resolve #(.width_p(16), .chunk_p(16)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v1), .ready_o(ready1), .s_i(s), .c_i(c),
    .cin_i(cin), .v_o(v_o1), .sum_o(sum1), .cout_o(cout1), .yumi_i(yumi1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic start(input logic [15:0] ss, input logic [15:0] cc, input logic ci);
    v = 1'b1; s = ss; c = cc; cin = ci;
    @(negedge clk);
    v = 1'b0;
  endtask

  // Counts cycles after accept until v_o; optionally holds junk on v_i meanwhile.
  task automatic wait_done(input bit hold_v, output int cyc);
    cyc = 0;
    if (hold_v) begin
      v = 1'b1; s = 16'hFFFF; c = 16'hFFFF; cin = 1'b1;
    end
    while (!v_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    v = 1'b0;
  endtask

  task automatic consume();
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  initial begin
    int          cyc;
    bit          stale;
    logic [15:0] rs, rc;
    logic        rci;
    logic [16:0] ref_sum;
    int          d;

    // Reset state
    #2;
    check("rst_v_o", 32'(v_o), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ready1", 32'(ready1), 32'd1);
    @(negedge clk);

    // Full carry ripple across every chunk boundary
    start(16'hFFFF, 16'h0001, 1'b0);
    check("ripple_busy_v_o", 32'(v_o), 32'd0);
    wait_done(1'b0, cyc);
    check("ripple_lat", 32'(cyc), 32'd4);
    check("ripple_sum", 32'(sum), 32'h0000);
    check("ripple_cout", 32'(cout), 32'd1);
    consume();
    check("ripple_idle_v_o", 32'(v_o), 32'd0);
    check("ripple_idle_ready", 32'(ready), 32'd1);

    // Mixed operands with carry-in
    start(16'h1234, 16'h0F0F, 1'b1);
    wait_done(1'b0, cyc);
    check("mix_lat", 32'(cyc), 32'd4);
    check("mix_sum", 32'(sum), 32'h2144);
    check("mix_cout", 32'(cout), 32'd0);

    // Stall in DONE with v_i asserted: nothing captured, outputs stable
    v = 1'b1; s = 16'hFFFF; c = 16'hFFFF; cin = 1'b1;
    #1;
    check("stall_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_v_o", 32'(v_o), 32'd1);
      check("stall_sum", 32'(sum), 32'h2144);
      check("stall_cout", 32'(cout), 32'd0);
      check("stall_ready", 32'(ready), 32'd0);
    end

    // Back-to-back: yumi and new operation in the same cycle
    yumi = 1'b1; v = 1'b1; s = 16'h8000; c = 16'h8000; cin = 1'b0;
    #1;
    check("b2b_ready", 32'(ready), 32'd1);
    @(negedge clk);
    yumi = 1'b0; v = 1'b0;
    check("b2b_busy_v_o", 32'(v_o), 32'd0);
    wait_done(1'b1, cyc);
    check("b2b_lat", 32'(cyc), 32'd4);
    check("b2b_sum", 32'(sum), 32'h0000);
    check("b2b_cout", 32'(cout), 32'd1);
    consume();

    // Asynchronous reset in BUSY cycle 2 (cout still holds 1 from last result)
    start(16'h1234, 16'h0F0F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_v_o", 32'(v_o), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    stale = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (v_o) stale = 1'b1;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    // Single-chunk configuration
    v1 = 1'b1; s = 16'hAAAA; c = 16'h5555; cin = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    cyc = 0;
    while (!v_o1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("one_lat", 32'(cyc), 32'd1);
    check("one_sum", 32'(sum1), 32'h0000);
    check("one_cout", 32'(cout1), 32'd1);
    yumi1 = 1'b1;
    @(negedge clk);
    yumi1 = 1'b0;
    check("one_idle_v_o", 32'(v_o1), 32'd0);

    // Randomized regression against a 17-bit reference add
    for (int i = 0; i < 3000; i++) begin
      rs  = 16'($urandom);
      rc  = 16'($urandom);
      rci = 1'($urandom_range(0, 1));
      d   = int'($urandom_range(0, 3));
      ref_sum = 17'(rs) + 17'(rc) + 17'(rci);
      start(rs, rc, rci);
      wait_done(bit'(i % 2), cyc);
      check("rnd_lat", 32'(cyc), 32'd4);
      repeat (d) @(negedge clk);
      check("rnd_sum", 32'(sum), 32'(ref_sum[15:0]));
      check("rnd_cout", 32'(cout), 32'(ref_sum[16]));
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
